// File: rtl/time_display_driver.sv
// time_display_driver
// -------------------
// Drives six active-low 7-segment digits (HH MM SS) from the binary time
// fields of the time-of-day counter.
//
// Each field is converted to BCD by a sequential shift-add-3 engine. The
// digits on the display only change when a complete conversion of all three
// fields is committed. The field currently being set can be flashed.
//
// Ports:
//   CLK        system clock
//   RST        asynchronous active-low reset
//   seconds    binary seconds (8 bits)
//   minutes    binary minutes (8 bits)
//   hours      binary hours (8 bits)
//   BLINK_SEL  flashing field: 00 none, 01 seconds, 10 minutes, 11 hours
//   HEX0..HEX5 active-low segments (bit0=a .. bit6=g), HEX0 = seconds ones
//   busy       high while a conversion is in progress
//   updated    one-cycle pulse when a new display value is committed
//
// Parameters:
//   BLINK_HALF clock cycles per blink half-period (visible or blank)

module time_display_driver #(
    parameter int BLINK_HALF = 12500000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] seconds,
    input  logic [7:0] minutes,
    input  logic [7:0] hours,
    input  logic [1:0] BLINK_SEL,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [6:0] HEX4,
    output logic [6:0] HEX5,
    output logic       busy,
    output logic       updated
);

    localparam int            CW       = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_HALF - 1);
    localparam logic [6:0]    SEG_DASH  = 7'b0111111;
    localparam logic [6:0]    SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

    state_t        state, state_next;
    logic [7:0]    snap_s, snap_m, snap_h;
    logic [19:0]   shift_reg;
    logic [2:0]    iter;
    logic [1:0]    field_idx;
    logic [11:0]   pend_s, pend_m, pend_h;
    logic [11:0]   disp_s, disp_m, disp_h;
    logic [CW-1:0] blink_cnt;
    logic          blank_phase;
    logic [1:0]    sel_q;

    logic          input_changed;
    logic [7:0]    field_bin;
    logic [19:0]   dd_src, dd_adj, dd_next;

    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return SEG_DASH;
        endcase
    endfunction

    // Returns {tens, ones}. Blanking wins over the out-of-range dash so the
    // selected field still visibly flashes while it holds a bad value.
    function automatic logic [13:0] field_segs(input logic [11:0] bcd, input logic blank);
        if (blank)
            return {SEG_BLANK, SEG_BLANK};
        else if (bcd[11:8] != 4'd0)
            return {SEG_DASH, SEG_DASH};
        else
            return {seg7(bcd[7:4]), seg7(bcd[3:0])};
    endfunction

    assign input_changed = ({hours, minutes, seconds} != {snap_h, snap_m, snap_s});
    assign busy          = (state != IDLE);

    // One double-dabble step. On the first step of a field the binary value
    // is taken straight from the snapshot with an empty BCD part, so no
    // separate load cycle is needed between fields.
    always_comb begin
        case (field_idx)
            2'd0:    field_bin = snap_s;
            2'd1:    field_bin = snap_m;
            default: field_bin = snap_h;
        endcase
        dd_src  = (iter == 3'd0) ? {12'd0, field_bin} : shift_reg;
        dd_adj  = {add3(dd_src[19:16]), add3(dd_src[15:12]), add3(dd_src[11:8]), dd_src[7:0]};
        dd_next = dd_adj << 1;
    end

    // Next-state logic of the conversion sequencer.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (input_changed) state_next = CONV;
            CONV:    if (iter == 3'd7 && field_idx == 2'd2) state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Conversion datapath: snapshot capture, shifting, per-field result
    // capture and the final commit into the displayed digits.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= IDLE;
            snap_s    <= 8'd0;
            snap_m    <= 8'd0;
            snap_h    <= 8'd0;
            shift_reg <= 20'd0;
            iter      <= 3'd0;
            field_idx <= 2'd0;
            pend_s    <= 12'd0;
            pend_m    <= 12'd0;
            pend_h    <= 12'd0;
            disp_s    <= 12'd0;
            disp_m    <= 12'd0;
            disp_h    <= 12'd0;
            updated   <= 1'b0;
        end else begin
            state   <= state_next;
            updated <= 1'b0;
            case (state)
                IDLE: begin
                    if (input_changed) begin
                        snap_s    <= seconds;
                        snap_m    <= minutes;
                        snap_h    <= hours;
                        shift_reg <= 20'd0;
                        iter      <= 3'd0;
                        field_idx <= 2'd0;
                    end
                end
                CONV: begin
                    shift_reg <= dd_next;
                    iter      <= iter + 3'd1;
                    if (iter == 3'd7) begin
                        case (field_idx)
                            2'd0:    pend_s <= dd_next[19:8];
                            2'd1:    pend_m <= dd_next[19:8];
                            default: pend_h <= dd_next[19:8];
                        endcase
                        field_idx <= field_idx + 2'd1;
                    end
                end
                COMMIT: begin
                    disp_s  <= pend_s;
                    disp_m  <= pend_m;
                    disp_h  <= pend_h;
                    updated <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Blink timer. A change of field select restarts the half-period in the
    // visible phase so a newly selected field is never blank at first.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            blink_cnt   <= '0;
            blank_phase <= 1'b0;
            sel_q       <= 2'b00;
        end else if (BLINK_SEL != sel_q) begin
            sel_q       <= BLINK_SEL;
            blink_cnt   <= '0;
            blank_phase <= 1'b0;
        end else if (blink_cnt == CNT_LAST) begin
            blink_cnt   <= '0;
            blank_phase <= ~blank_phase;
        end else begin
            blink_cnt <= blink_cnt + CW'(1);
        end
    end

    // The blink mask uses the registered select so it stays aligned with
    // the phase restart that follows a select change.
    always_comb begin
        {HEX1, HEX0} = field_segs(disp_s, blank_phase && sel_q == 2'b01);
        {HEX3, HEX2} = field_segs(disp_m, blank_phase && sel_q == 2'b10);
        {HEX5, HEX4} = field_segs(disp_h, blank_phase && sel_q == 2'b11);
    end

endmodule

// File: tb/tb_time_display_driver.sv
// tb_time_display_driver
// ----------------------
// Self-checking bench for time_display_driver (BLINK_HALF = 4).
// Every expected display is written out by hand. Commit results go through a
// queue that a monitor drains on each updated pulse; reset, busy timing and
// blink behaviour are checked directly by the stimulus thread.

module tb_time_display_driver;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] DSH = 7'b0111111;
    localparam logic [6:0] BLK = 7'b1111111;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] seconds, minutes, hours;
    logic [1:0] BLINK_SEL;
    logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
    logic       busy, updated;

    logic [41:0] sb[$];
    int          total_checks = 0;
    int          pass_checks  = 0;
    int          upd_count    = 0;

    time_display_driver #(.BLINK_HALF(4)) dut (
        .CLK(CLK), .RST(RST),
        .seconds(seconds), .minutes(minutes), .hours(hours),
        .BLINK_SEL(BLINK_SEL),
        .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5),
        .busy(busy), .updated(updated)
    );

    always #5 CLK = ~CLK;

    wire [41:0] hex_all = {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};

    task automatic check(input string name, input logic [41:0] act, input logic [41:0] exp);
        total_checks++;
        if (act === exp) pass_checks++;
        else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Wait until all queued commits have been seen and the DUT is idle.
    task automatic wait_done(input string name);
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 150) begin
            tick();
            n++;
        end
        check({name, "_timeout"}, 42'(n < 150), 42'd1);
    endtask

    // Monitor: every updated pulse must match the oldest queued expectation.
    always @(negedge CLK) begin
        if (RST && updated) begin
            upd_count++;
            if (sb.size() == 0) begin
                check("unexpected_update", 42'd1, 42'd0);
            end else begin
                check("commit", hex_all, sb.pop_front());
            end
        end
    end

    initial begin
        int          busy_cycles;
        logic        seen;
        logic        blank;
        logic [41:0] exp_v;

        // Reset with all inputs zero.
        RST = 1'b0; seconds = 0; minutes = 0; hours = 0; BLINK_SEL = 2'b00;
        repeat (3) tick();
        check("reset_hex", hex_all, {S0, S0, S0, S0, S0, S0});
        check("reset_busy", 42'(busy), 42'd0);
        check("reset_updated", 42'(updated), 42'd0);
        RST = 1'b1;
        repeat (6) tick();
        check("idle_busy", 42'(busy), 42'd0);
        check("idle_no_update", 42'(upd_count), 42'd0);
        check("idle_hex", hex_all, {S0, S0, S0, S0, S0, S0});

        // 23:59:58 with busy-length and pulse alignment.
        hours = 23; minutes = 59; seconds = 58;
        sb.push_back({S2, S3, S5, S9, S5, S8});
        busy_cycles = 0; seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (busy) begin
                busy_cycles++;
                seen = 1'b1;
                if (busy_cycles == 25) check("hex_held_during_conv", hex_all, {S0, S0, S0, S0, S0, S0});
            end else if (seen) begin
                check("updated_at_busy_fall", 42'(updated), 42'd1);
                break;
            end
        end
        check("busy_cycles", 42'(busy_cycles), 42'd25);
        wait_done("t235958");

        // Change while busy: seconds 07 then 08, two commits.
        seconds = 7;
        sb.push_back({S2, S3, S5, S9, S0, S7});
        sb.push_back({S2, S3, S5, S9, S0, S8});
        repeat (6) tick();
        check("busy_midconv", 42'(busy), 42'd1);
        seconds = 8;
        wait_done("restart");
        check("update_count_after_two", 42'(upd_count), 42'd3);

        // Blink minutes 45.
        minutes = 45;
        sb.push_back({S2, S3, S4, S5, S0, S8});
        wait_done("m45");
        BLINK_SEL = 2'b10;
        for (int i = 1; i <= 14; i++) begin
            tick();
            blank = (((i - 1) / 4) % 2) == 1;
            exp_v = blank ? {S2, S3, BLK, BLK, S0, S8} : {S2, S3, S4, S5, S0, S8};
            if (i % 2 == 1 || i == 14) check($sformatf("blink_min_%0d", i), hex_all, exp_v);
        end
        BLINK_SEL = 2'b01;
        tick();
        check("switch_visible", hex_all, {S2, S3, S4, S5, S0, S8});
        repeat (3) tick();
        check("sec_visible_end", hex_all, {S2, S3, S4, S5, S0, S8});
        tick();
        check("sec_blank", hex_all, {S2, S3, S4, S5, BLK, BLK});
        BLINK_SEL = 2'b00;
        tick();
        check("blink_off", hex_all, {S2, S3, S4, S5, S0, S8});

        // Out-of-range seconds.
        seconds = 150;
        sb.push_back({S2, S3, S4, S5, DSH, DSH});
        wait_done("s150");

        // Reset in the middle of a conversion of hours=12.
        hours = 12;
        repeat (10) tick();
        check("conv_running", 42'(busy), 42'd1);
        RST = 1'b0;
        #1;
        check("midreset_hex", hex_all, {S0, S0, S0, S0, S0, S0});
        check("midreset_busy", 42'(busy), 42'd0);
        repeat (2) tick();
        RST = 1'b1;
        sb.push_back({S1, S2, S4, S5, DSH, DSH});
        wait_done("h12");
        check("total_updates", 42'(upd_count), 42'd6);

        $display("%0d/%0d checks passed", pass_checks, total_checks);
        $finish;
    end

endmodule

// File: doc/time_display_driver.md
Name: time_display_driver

Overview:
- Downstream consumer of the time-of-day counter. Takes the binary seconds, minutes and hours fields and drives six active-low 7-segment digits (HH MM SS).
- Converts each field to BCD with a sequential shift-add-3 (double-dabble) engine, holding the last committed display until a new conversion completes.
- Flashes the field being set, selected by the same 2-bit field select used by the time-set path.

Parameters:
- BLINK_HALF, 12500000, clock cycles per blink half-period (visible or blank); 0.25 s at 50 MHz.

Ports:
- CLK  input  1  system clock.
- RST  input  1  asynchronous active-low reset.
- seconds  input  8  binary seconds from the time counter.
- minutes  input  8  binary minutes.
- hours  input  8  binary hours.
- BLINK_SEL  input  2  flashing field: 00 none, 01 seconds, 10 minutes, 11 hours.
- HEX0  output  7  seconds ones digit; active-low, bit0=a … bit6=g.
- HEX1  output  7  seconds tens digit.
- HEX2  output  7  minutes ones digit.
- HEX3  output  7  minutes tens digit.
- HEX4  output  7  hours ones digit.
- HEX5  output  7  hours tens digit.
- busy  output  1  high while a conversion is in progress.
- updated  output  1  one-cycle pulse when a new display value is committed.

Behaviour:
- Reset (async, RST=0):
  - snapshot registers = 0, committed BCD = 0, FSM = IDLE, blink counter = 0, blink phase = visible.
  - busy=0, updated=0; every HEX = 7'b1000000 ("0").
- FSM states: IDLE, CONV, COMMIT.
- IDLE:
  - On each edge, compare {hours, minutes, seconds} with the snapshot.
  - If they differ: load the snapshot, clear the shift registers, set field index to 0 (seconds), go to CONV, set busy=1.
- CONV:
  - 8 shift-add-3 iterations per field, one per clock, over a 12-bit BCD + 8-bit binary shift register.
  - Fields are done in order seconds, minutes, hours.
  - After the 8th iteration, store the field's 3-digit BCD result in a pending register and advance the index.
  - After the hours field (24 cycles total), go to COMMIT.
- COMMIT:
  - Copy all pending digits into the committed registers, pulse updated=1 for exactly this cycle, clear busy, return to IDLE.
- Latency:
  - Change captured at edge k. CONV occupies edges k+1 to k+24; COMMIT at edge k+25.
  - HEX reflects the new value after edge k+25.
  - busy is high from after edge k through edge k+25.
- Input changes during CONV are ignored; the conversion is never restarted. The IDLE compare after COMMIT picks up any difference, so the latest input is always displayed within 52 cycles.
- Decode is combinational from committed BCD and the blink mask. No other path changes HEX.
- Segment codes:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- Range: if a field's hundreds digit is nonzero (value ≥ 100), both of its digits show a dash, 7'b0111111.
- Blink timer:
  - Counter counts 0 to BLINK_HALF-1, then wraps and toggles the phase.
  - In the blank phase, both digits of the selected field = 7'b1111111; other digits are unaffected.
  - BLINK_SEL=00 never blanks.
  - Any change of BLINK_SEL (detected against a registered copy) clears the counter and forces the visible phase on the next edge.
- Reset mid-conversion: all state returns to reset values immediately; the partial result is discarded. After release, a conversion starts only if the inputs are nonzero.

Test Plan:
- Apply reset with all inputs 0 -> every HEX = 1000000, busy=0, updated never pulses, no conversion starts.
- Drive h=23, m=59, s=58 at edge k -> busy high for 25 cycles; a single updated pulse at edge k+25; HEX5..HEX0 = 0100100, 0110000, 0010010, 0010000, 0010010, 0000000.
- Drive s=7, then s=8 at k+5 while busy -> first commit shows seconds "07"; a second conversion follows; final HEX1/HEX0 = 1000000/0000000; exactly two updated pulses.
- Set BLINK_HALF=4, m=45, BLINK_SEL=10 -> HEX3/HEX2 alternate 0011001/0010010 and 1111111/1111111 every 4 cycles; HEX5, HEX4, HEX1, HEX0 stay steady. Switch to 01 mid-blank -> minutes visible on the next edge; seconds start visible.
- Drive s=150 -> after commit, HEX1 = HEX0 = 0111111; other digits unchanged.
- Assert RST at cycle 10 of a conversion of h=12 -> HEX all 1000000, busy=0, no updated pulse. After release with h=12 held -> conversion restarts; HEX5/HEX4 = 1111001/0100100.
